sample_recorder: RTL and testbench
==================================

SAMPLE_RECORDER -- requirements
Module: sample_recorder

Interface
REQ-001 Parameter ADDR_W, default 15: sample memory address width; depth = 2^ADDR_W words (32768).
REQ-002 Parameter THRESH, default 1024: trigger amplitude threshold, unsigned, 16 bits.
REQ-003 Port clk  input  1: single clock; all logic rising-edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port en  input  1: sample strobe; sample_in valid on cycles with en=1.
REQ-006 Port go  input  1: single-cycle start pulse.
REQ-007 Port stop  input  1: single-cycle abort/finish pulse.
REQ-008 Port sample_in  input  16: signed two's-complement audio sample.
REQ-009 Port wr_en  output  1: write strobe to external sample RAM, one cycle per word.
REQ-010 Port wr_addr  output  ADDR_W: RAM write address.
REQ-011 Port wr_data  output  16: RAM write data.
REQ-012 Port busy  output  1: high in ARMED or RECORD.
REQ-013 Port done  output  1: high in DONE.
REQ-014 Port length  output  ADDR_W+1: number of words written in the last take.

Function
REQ-015 FSM states IDLE, ARMED, RECORD, DONE; all outputs registered.
REQ-016 IDLE: go=1 -> ARMED; length cleared to 0.
REQ-017 ARMED: en=1 with |sample_in| >= THRESH -> RECORD; that triggering sample is word 0.
REQ-018 |sample_in| computed unsigned 16-bit; -32768 treated as 32768 (no overflow).
REQ-019 RECORD/ARMED-trigger accept: wr_en=1, wr_addr=count, wr_data=sample_in on the cycle after the accepting en (latency 1); count and length increment by 1 per accepted sample.
REQ-020 en=0 cycles: wr_en=0, wr_addr/wr_data hold last values.
REQ-021 Accepting word at address 2^ADDR_W-1 -> DONE, length=2^ADDR_W; no address wrap, no further writes.
REQ-022 stop=1 in ARMED or RECORD -> DONE; length = words written so far (0 if from ARMED).
REQ-023 stop and en same cycle in RECORD: sample written and counted, then DONE.
REQ-024 DONE: done held high, length held; en ignored; go=1 -> ARMED, length and count cleared.
REQ-025 go while ARMED or RECORD ignored; stop in IDLE or DONE ignored.
REQ-026 en outside ARMED/RECORD never produces wr_en.

Reset
REQ-027 reset=1 at clock edge: state=IDLE, count=0, length=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-028 reset mid-take abandons take; no wr_en on the cycle after the reset edge; reset dominates go/stop/en.

Configuration
REQ-029 Macro SAMPLE_RECORDER_TRIGGER_EN defined: ARMED waits for threshold trigger per REQ-017.
REQ-030 Macro undefined: ARMED state and THRESH unused; go in IDLE/DONE -> RECORD directly; first en after go is word 0.

Verification
REQ-031 reset, go, en with sample_in 100, 2000, -3000 (macro on) -> 100 not written; wr_addr 0/1 get 2000/-3000 (0x07D0, 0xF448); busy=1.
REQ-032 macro on, ARMED, sample_in=-32768 with en -> trigger; wr_data=0x8000 at wr_addr 0.
REQ-033 record 5 samples then stop with en in same cycle -> 6 writes, addresses 0..5, done=1, length=6, busy=0.
REQ-034 ADDR_W=4, 20 strobes after trigger -> exactly 16 writes, addr 0..15, length=16, done=1, no write to addr 0 after 15.
REQ-035 reset after 3 writes -> next cycle wr_en=0, state IDLE, length=0; subsequent en produces no writes.
REQ-036 DONE with length=6, go, macro off -> length=0, RECORD; next en writes wr_addr 0.

Source files
------------

// File: rtl/sample_recorder.sv
// Triggered sample recorder: streams accepted audio samples to an external RAM.
// Define SAMPLE_RECORDER_TRIGGER_EN to arm on a |sample| >= THRESH trigger before recording.
module sample_recorder #(
    parameter int          ADDR_W = 15,
    parameter logic [15:0] THRESH = 16'd1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              go,
    input  logic              stop,
    input  logic [15:0]       sample_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   length
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RECORD,
        S_DONE
    } state_t;

`ifdef SAMPLE_RECORDER_TRIGGER_EN
    localparam state_t START = S_ARMED;
`else
    localparam state_t START = S_RECORD;
`endif

    state_t              r_state;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [15:0]         r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W:0]     r_length;

    logic                w_accept;
    logic                w_last;

`ifdef SAMPLE_RECORDER_TRIGGER_EN
    // Unsigned magnitude; -32768 maps cleanly to 0x8000.
    logic [15:0]         w_abs;
    assign w_abs = sample_in[15] ? (~sample_in + 16'd1) : sample_in;
`endif

    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            S_RECORD: w_accept = en;
`ifdef SAMPLE_RECORDER_TRIGGER_EN
            S_ARMED:  w_accept = en && (w_abs >= THRESH);
`endif
            default:  w_accept = 1'b0;
        endcase
    end

    assign w_last = &r_length[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_length  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        r_state  <= START;
                        r_length <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                S_ARMED, S_RECORD: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_length[ADDR_W-1:0];
                        r_wr_data <= sample_in;
                        r_length  <= r_length + 1'b1;
                        r_state   <= S_RECORD;
                    end
                    // Final word or abort: the same-cycle sample is kept.
                    if (stop || (w_accept && w_last)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign length  = r_length;

endmodule

// File: tb/tb_sample_recorder.sv
// Directed self-checking bench for sample_recorder (ADDR_W=4, THRESH=1024).
// Covers both builds of SAMPLE_RECORDER_TRIGGER_EN.
module tb_sample_recorder;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          go;
    logic          stop;
    logic [15:0]   sample_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   length;

    int checks   = 0;
    int failures = 0;
    int nwr;

    sample_recorder #(.ADDR_W(AW), .THRESH(16'd1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .go        (go),
        .stop      (stop),
        .sample_in (sample_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .length    (length)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [15:0] s, input logic g, input logic p);
        en = e;
        sample_in = s;
        go = g;
        stop = p;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_length", length, 0);

        // stop in IDLE is ignored
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        chk("idle_stop_done", done, 0);

        drive(1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        chk("go_busy", busy, 1);
        chk("go_length", length, 0);

`ifdef SAMPLE_RECORDER_TRIGGER_EN
        drive(1'b1, 16'd100, 1'b0, 1'b0);
        tick();
        chk("below_thresh_wr_en", wr_en, 0);
        chk("armed_busy", busy, 1);
`endif
        drive(1'b1, 16'd2000, 1'b0, 1'b0);
        tick();
        chk("w0_en", wr_en, 1);
        chk("w0_addr", wr_addr, 0);
        chk("w0_data", wr_data, 16'h07D0);
        drive(1'b1, 16'hF448, 1'b0, 1'b0);
        tick();
        chk("w1_en", wr_en, 1);
        chk("w1_addr", wr_addr, 1);
        chk("w1_data", wr_data, 16'hF448);
        chk("rec_busy", busy, 1);
        drive(1'b0, 16'h1234, 1'b0, 1'b0);
        tick();
        chk("idle_en_wr_en", wr_en, 0);
        chk("hold_addr", wr_addr, 1);
        chk("hold_data", wr_data, 16'hF448);

        drive(1'b1, 16'd10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd30, 1'b0, 1'b0);
        tick();
        chk("w4_addr", wr_addr, 4);
        chk("len5", length, 5);
        drive(1'b1, 16'd40, 1'b0, 1'b1);
        tick();
        chk("stop_en_wr_en", wr_en, 1);
        chk("stop_en_addr", wr_addr, 5);
        chk("stop_en_data", wr_data, 16'd40);
        chk("stop_done", done, 1);
        chk("stop_busy", busy, 0);
        chk("stop_length", length, 6);

        // DONE ignores en and stop
        drive(1'b1, 16'd2000, 1'b0, 1'b1);
        tick();
        chk("done_en_wr_en", wr_en, 0);
        chk("done_hold", done, 1);
        chk("done_len_hold", length, 6);

        drive(1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        chk("rego_length", length, 0);
        chk("rego_busy", busy, 1);
        chk("rego_done", done, 0);
`ifdef SAMPLE_RECORDER_TRIGGER_EN
        drive(1'b1, 16'd5, 1'b0, 1'b0);
        tick();
        chk("armed_small_wr_en", wr_en, 0);
        drive(1'b1, 16'h8000, 1'b0, 1'b0);
        tick();
        chk("neg_full_en", wr_en, 1);
        chk("neg_full_addr", wr_addr, 0);
        chk("neg_full_data", wr_data, 16'h8000);
`else
        drive(1'b1, 16'd5, 1'b0, 1'b0);
        tick();
        chk("direct_w0_en", wr_en, 1);
        chk("direct_w0_addr", wr_addr, 0);
        chk("direct_w0_data", wr_data, 16'd5);
`endif
        // go while recording is ignored
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        chk("go_ign_len", length, 1);
        chk("go_ign_busy", busy, 1);

        drive(1'b1, 16'd3000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd4000, 1'b0, 1'b0);
        tick();
        chk("pre_rst_addr", wr_addr, 2);
        reset = 1'b1;
        drive(1'b1, 16'd5000, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_len", length, 0);
        nwr = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'd3000, 1'b0, 1'b0);
            tick();
            if (wr_en) nwr++;
        end
        chk("post_rst_writes", nwr, 0);

        drive(1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'd2000 + 16'(i), 1'b0, 1'b0);
            tick();
            if (wr_en) begin
                chk("full_addr", wr_addr, nwr);
                nwr++;
            end
        end
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("full_writes", nwr, 16);
        chk("full_length", length, 16);
        chk("full_done", done, 1);
        chk("full_busy", busy, 0);

        // abort before any word is written
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("abort_done", done, 1);
        chk("abort_len", length, 0);
        chk("abort_wr_en", wr_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
